// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single FIFO write port.
// Grants one requester at a time for bursts of up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk_wr,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*WIDTH-1:0]         req_data,
    input  logic [NREQ-1:0]               req_last,
    output logic [NREQ-1:0]               req_ready,
    input  logic                          flag_full,
    output logic                          wr_en,
    output logic [WIDTH-1:0]              wr_data,
    output logic [(NREQ>1 ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                          busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last_owner, last_owner_n;
    logic [IW-1:0] pick;
    logic [CW-1:0] beats, beats_n, beats_inc;
    logic          found, own_valid, own_last, accept, done;
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : gen_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // First valid requester searching upward from last_owner+1, wrapping
    always_comb begin : rr_search
        int k;
        logic [IW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        k     = 0;
        idx   = '0;
        for (int d = 1; d <= NREQ; d++) begin
            k   = (int'(last_owner) + d) % NREQ;
            idx = IW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign accept    = rst_n && (state == BURST) && own_valid && !flag_full;
    assign beats_inc = beats + CW'(1);
    assign done      = own_last || (beats_inc == CW'(MAX_BURST));

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        beats_n      = beats;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BURST;
                    owner_n = pick;
                    beats_n = '0;
                end
            end
            BURST: begin
                if (!own_valid) begin
                    state_n      = IDLE;
                    last_owner_n = owner;
                end else if (!flag_full) begin
                    beats_n = beats_inc;
                    if (done) begin
                        state_n      = IDLE;
                        last_owner_n = owner;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset gates the handshake combinationally, even mid-burst
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == BURST)) req_ready[owner] = !flag_full;
    end

    assign wr_en    = accept;
    assign wr_data  = accept ? data_arr[owner] : '0;
    assign grant_id = owner;
    assign busy     = (state == BURST);

    always_ff @(posedge clk_wr) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            beats      <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            beats      <= beats_n;
        end
    end

endmodule
